// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchroniser, stability
// counter and registered press/release pulses per channel.
module button_debouncer #(
  parameter int BTN_COUNT       = 7,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BTN_COUNT-1:0] btn,
  output logic [BTN_COUNT-1:0] level,
  output logic [BTN_COUNT-1:0] trigger,
  output logic [BTN_COUNT-1:0] released
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [BTN_COUNT-1:0] s1;
  logic [BTN_COUNT-1:0] s2;
  logic [CW-1:0]        cnt [BTN_COUNT];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1       <= '0;
      s2       <= '0;
      level    <= '0;
      trigger  <= '0;
      released <= '0;
      for (int i = 0; i < BTN_COUNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1       <= btn;
      s2       <= s1;
      trigger  <= '0;
      released <= '0;
      for (int i = 0; i < BTN_COUNT; i++) begin
        // Any sample matching level restarts the stability window.
        if (s2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != LAST) begin
          cnt[i] <= cnt[i] + CW'(1);
        end else begin
          cnt[i]      <= '0;
          level[i]    <= s2[i];
          trigger[i]  <= s2[i];
          released[i] <= ~s2[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer against a
// sample-history reference model.
module tb_button_debouncer;

  localparam int N = 7;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn;
  logic [N-1:0] level;
  logic [N-1:0] trigger;
  logic [N-1:0] released;

  button_debouncer #(
    .BTN_COUNT      (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn),
    .level   (level),
    .trigger (trigger),
    .released(released)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [N-1:0] q [$];
  logic [N-1:0] mlev;
  logic [N-1:0] mtrig;
  logic [N-1:0] mrel;

  int tcnt [N];
  int rcnt [N];
  int tcyc [N];
  logic [N-1:0] tvec;
  int tvec_hits;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Level flips once the synchronised samples of the last D cycles
  // (btn as seen two edges earlier) all disagree with it.
  task automatic model(input logic rn, input logic [N-1:0] b);
    bit stable;
    mtrig = '0;
    mrel  = '0;
    if (!rn) begin
      q.delete();
      repeat (D + 2) q.push_back('0);
      mlev = '0;
    end else begin
      q.push_back(b);
      for (int i = 0; i < N; i++) begin
        stable = 1'b1;
        for (int k = 1; k <= D; k++)
          if (q[k][i] == mlev[i]) stable = 1'b0;
        if (stable) begin
          mlev[i]  = ~mlev[i];
          mtrig[i] = mlev[i];
          mrel[i]  = ~mlev[i];
        end
      end
      void'(q.pop_front());
    end
  endtask

  task automatic clr_track();
    for (int i = 0; i < N; i++) begin
      tcnt[i] = 0;
      rcnt[i] = 0;
      tcyc[i] = -1;
    end
    tvec      = '0;
    tvec_hits = 0;
  endtask

  task automatic step(input logic rn, input logic [N-1:0] b);
    @(negedge clk);
    reset_n = rn;
    btn     = b;
    @(posedge clk);
    model(rn, b);
    cyc++;
    #1;
    check("level", 32'(level), 32'(mlev));
    check("trigger", 32'(trigger), 32'(mtrig));
    check("released", 32'(released), 32'(mrel));
    check("excl", 32'(trigger & released), 32'd0);
    if (trigger != '0) begin
      tvec = trigger;
      tvec_hits++;
    end
    for (int i = 0; i < N; i++) begin
      if (trigger[i]) begin
        tcnt[i]++;
        if (tcyc[i] < 0) tcyc[i] = cyc;
      end
      if (released[i]) rcnt[i]++;
    end
  endtask

  int c0;
  logic [N-1:0] cur;
  logic rn;

  initial begin
    reset_n = 1'b0;
    btn     = '0;
    mlev    = '0;
    repeat (D + 2) q.push_back('0);
    clr_track();

    // Reset with all buttons held high.
    repeat (4) begin
      step(1'b0, 7'h7F);
      check("rst_level", 32'(level), 32'd0);
    end
    repeat (5) step(1'b1, 7'h00);

    // Clean press on channel 0.
    clr_track();
    step(1'b1, 7'h01);
    c0 = cyc;
    repeat (30) step(1'b1, 7'h01);
    check("press_lat", 32'(tcyc[0] - c0), 32'(D + 1));
    check("press_cnt", 32'(tcnt[0]), 32'd1);
    check("press_rel", 32'(rcnt[0]), 32'd0);
    check("press_lvl", 32'(level[0]), 32'd1);

    // Clean release on channel 0.
    clr_track();
    step(1'b1, 7'h00);
    c0 = cyc;
    repeat (D) step(1'b1, 7'h00);
    check("rel_early", 32'(rcnt[0]), 32'd0);
    step(1'b1, 7'h00);
    check("rel_lat", 32'(released[0]), 32'd1);
    repeat (12) step(1'b1, 7'h00);
    check("rel_cnt", 32'(rcnt[0]), 32'd1);
    check("rel_trig", 32'(tcnt[0]), 32'd0);

    // Glitch on channel 3.
    clr_track();
    repeat (15) step(1'b1, 7'h08);
    step(1'b1, 7'h00);
    step(1'b1, 7'h08);
    c0 = cyc;
    repeat (30) step(1'b1, 7'h08);
    check("glitch_lat", 32'(tcyc[3] - c0), 32'(D + 1));
    check("glitch_cnt", 32'(tcnt[3]), 32'd1);

    // Short pulse on channel 2, then release channel 3.
    clr_track();
    repeat (10) step(1'b1, 7'h0C);
    repeat (30) step(1'b1, 7'h00);
    check("short_trig", 32'(tcnt[2]), 32'd0);
    check("short_rel", 32'(rcnt[2]), 32'd0);
    check("short_lvl", 32'(level[2]), 32'd0);

    // Simultaneous press on alternating channels.
    clr_track();
    repeat (30) step(1'b1, 7'h55);
    check("indep_vec", 32'(tvec), 32'h55);
    check("indep_hits", 32'(tvec_hits), 32'd1);
    repeat (30) step(1'b1, 7'h00);

    // Reset in the middle of a count, button held throughout.
    clr_track();
    repeat (12) step(1'b1, 7'h02);
    repeat (2) step(1'b0, 7'h02);
    check("mid_none", 32'(tcnt[1]), 32'd0);
    clr_track();
    step(1'b1, 7'h02);
    c0 = cyc;
    repeat (30) step(1'b1, 7'h02);
    check("mid_lat", 32'(tcyc[1] - c0), 32'(D + 1));
    check("mid_cnt", 32'(tcnt[1]), 32'd1);

    // Random bouncing with occasional resets.
    cur = 7'h02;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) cur[i] = ~cur[i];
      rn = ($urandom_range(0, 499) != 0);
      step(rn, cur);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
